// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-detected, masked, priority-encoded interrupt requester with compare timer
// and a small MASK/PENDING/CAUSE/TIMER_CMP register port.
module irq_ctrl #(
    parameter int NUM_SRC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               ir_out,
    input  logic               ir_taken,
    input  logic               eret,
    input  logic               wr_en,
    input  logic [1:0]         wr_addr,
    input  logic [31:0]        wr_data,
    input  logic [1:0]         rd_addr,
    output logic [31:0]        rd_data
);
    localparam int N = NUM_SRC + 1;
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    state_t             state, state_nx;
    logic [N-1:0]       pending, pending_nx, mask, masked_q, sets;
    logic [NUM_SRC-1:0] irq_prev;
    logic [31:0]        tcmp, count;
    logic [3:0]         active_id, lowest_id;
    logic               fire, taken;
    assign fire  = (tcmp != 32'd0) && (count == tcmp);
    assign sets  = {fire, irq_src & ~irq_prev};
    assign taken = (state == REQ) && ir_taken;
    always_comb begin
        lowest_id = 4'd0;
        for (int i = N - 1; i >= 0; i--)
            if (masked_q[i]) lowest_id = 4'(i);
    end
    // set beats W1C; the taken source beats a concurrent set
    always_comb begin
        pending_nx = pending;
        if (wr_en && wr_addr == 2'd1) pending_nx = pending_nx & ~wr_data[N-1:0];
        pending_nx = pending_nx | sets;
        if (taken) pending_nx = pending_nx & ~({{(N-1){1'b0}}, 1'b1} << active_id);
    end
    always_comb begin
        state_nx = (state == IDLE && masked_q != '0) ? REQ :
                   (state == REQ && ir_taken)        ? SERVICE :
                   (state == SERVICE && eret)        ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ir_out    <= 1'b0;
            rd_data   <= 32'd0;
            pending   <= '0;
            mask      <= '0;
            masked_q  <= '0;
            tcmp      <= 32'd0;
            count     <= 32'd0;
            irq_prev  <= '0;
            active_id <= 4'd0;
        end else begin
            state    <= state_nx;
            ir_out   <= (state_nx == REQ);
            pending  <= pending_nx;
            // registered view of enabled pending sources drives the IDLE decision
            masked_q <= pending & mask;
            irq_prev <= irq_src;
            if (state == IDLE && masked_q != '0) active_id <= lowest_id;
            if (wr_en && wr_addr == 2'd0) mask <= wr_data[N-1:0];
            if (wr_en && wr_addr == 2'd3) begin
                tcmp  <= wr_data;
                count <= 32'd0;
            end else begin
                count <= fire ? 32'd0 : (tcmp != 32'd0) ? count + 32'd1 : count;
            end
            rd_data <= (rd_addr == 2'd0) ? 32'(mask) :
                       (rd_addr == 2'd1) ? 32'(pending) :
                       (rd_addr == 2'd2) ? {state != IDLE, 27'd0, active_id} : tcmp;
        end
    end
endmodule
